// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding control slice.
// fwd_sel_e : EX operand select encoding (regfile / MEM-WB / EX-MEM).
// slot_t    : one in-flight pipeline shadow slot {valid, rd, regwrite, is_load}.
// BUBBLE    : empty slot inserted on flush, stall or no valid ID instruction.
// slot_writes(): true when a slot will write a given non-zero register.
// SLOT_RD_W must match the REG_ADDR_W used by hazard_forward_ctrl.
package hazard_pkg;

  localparam int unsigned SLOT_RD_W = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 regwrite;
    logic                 is_load;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  // Register 0 is hard-wired zero, so it never counts as written.
  function automatic logic slot_writes(slot_t s, logic [SLOT_RD_W-1:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_src_cmp.sv
// hazard_src_cmp: combinational compare of one ID source operand against the
// ID/EX (s_ex) and EX/MEM (s_mem) shadow slots.
// Ports: id_valid, rs, rs_used, s_ex, s_mem in; fwd_nxt (next registered
// select for this source) and hazard (this source needs a stall) out.
// Macro HAZARD_FWD_EN: defined -> forwarding with load-use stall only;
// undefined -> no forwarding, stall on any dependency in s_ex or s_mem.
module hazard_src_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = SLOT_RD_W
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  slot_t                 s_ex,
  input  slot_t                 s_mem,
  output logic [1:0]            fwd_nxt,
  output logic                  hazard
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = rs_used && slot_writes(s_ex, rs);
    mem_hit = rs_used && slot_writes(s_mem, rs);
`ifdef HAZARD_FWD_EN
    // EX/MEM wins over MEM/WB; a load hit in s_ex always stalls, so its
    // FWD_MEM select is never latched.
    fwd_nxt = ex_hit ? FWD_MEM : (mem_hit ? FWD_WB : FWD_RF);
    hazard  = id_valid && ex_hit && s_ex.is_load;
`else
    fwd_nxt = FWD_RF;
    hazard  = id_valid && (ex_hit || mem_hit);
`endif
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: tracks in-flight register writes and produces
// registered EX operand forward selects, a combinational load-use stall,
// and a saturating stall-cycle counter.
// Ports: clk, rst_n (sync, active-low); ID fields id_valid, id_rs, id_rs_used,
// id_rd, id_regwrite, id_is_load; ex_flush, mem_wait controls;
// stall (comb), fwd_sel (registered, 2 bits per source), stall_cnt.
// Macro HAZARD_FWD_EN selects forwarding (defined) or stall-only (undefined).
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_regwrite,
  input  logic                          id_is_load,
  input  logic                          ex_flush,
  input  logic                          mem_wait,
  output logic                          stall,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic [CNT_W-1:0]              stall_cnt
);

  // The MEM/WB slot is never compared (write-through regfile covers it),
  // so only the ID/EX and EX/MEM slots are stored.
  slot_t                s_ex_q, s_ex_d;
  slot_t                s_mem_q, s_mem_d;
  slot_t                id_slot;
  logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d, fwd_nxt;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]   src_hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
      .id_valid (id_valid),
      .rs       (id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used  (id_rs_used[i]),
      .s_ex     (s_ex_q),
      .s_mem    (s_mem_q),
      .fwd_nxt  (fwd_nxt[2*i +: 2]),
      .hazard   (src_hazard[i])
    );
  end

  always_comb begin
    stall            = (|src_hazard) && !ex_flush && !mem_wait;
    id_slot.valid    = 1'b1;
    id_slot.rd       = id_rd;
    id_slot.regwrite = id_regwrite;
    id_slot.is_load  = id_is_load;

    s_ex_d      = s_ex_q;
    s_mem_d     = s_mem_q;
    fwd_sel_d   = fwd_sel_q;
    stall_cnt_d = stall_cnt_q;

    if (!mem_wait) begin
      s_mem_d = s_ex_q;
      if (ex_flush || stall || !id_valid) begin
        s_ex_d    = BUBBLE;
        fwd_sel_d = '0;
      end else begin
        s_ex_d    = id_slot;
        fwd_sel_d = fwd_nxt;
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ex_q      <= BUBBLE;
      s_mem_q     <= BUBBLE;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      s_ex_q      <= s_ex_d;
      s_mem_q     <= s_mem_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    fwd_sel   = fwd_sel_q;
    stall_cnt = stall_cnt_q;
  end

endmodule
